// File: rtl/lt24_window_blitter_pkg.sv
// Shared definitions for the LT24 window blitter: panel geometry, FSM states
// and a few RGB565 colours used by the game screens.
package lt24_window_blitter_pkg;

   localparam int LCD_WIDTH  = 240;
   localparam int LCD_HEIGHT = 320;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_FINISH = 3'd4
   } blit_state_t;

   localparam logic [15:0] RGB_BLACK  = 16'h0000;
   localparam logic [15:0] RGB_GREEN  = 16'h07E0;
   localparam logic [15:0] RGB_RED    = 16'hF800;
   localparam logic [15:0] RGB_BLUE   = 16'h001F;
   localparam logic [15:0] RGB_YELLOW = 16'hFFE0;

endpackage

// File: rtl/lt24_window_counter.sv
// Raster x/y counter over an inclusive window; load jumps to the top-left
// corner, advance steps one pixel in raster order, last flags the final pixel.
module lt24_window_counter #(
   parameter int XW = 8,
   parameter int YW = 9
) (
   input  logic          clock,
   input  logic          n_reset,
   input  logic          load,
   input  logic          advance,
   input  logic [XW-1:0] load_x0,
   input  logic [XW-1:0] load_x1,
   input  logic [YW-1:0] load_y0,
   input  logic [YW-1:0] load_y1,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          last
);

   logic [XW-1:0] x0_q;
   logic [XW-1:0] x1_q;
   logic [YW-1:0] y1_q;

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         x0_q <= '0;
         x1_q <= '0;
         y1_q <= '0;
         x    <= '0;
         y    <= '0;
      end else if (load) begin
         x0_q <= load_x0;
         x1_q <= load_x1;
         y1_q <= load_y1;
         x    <= load_x0;
         y    <= load_y0;
      end else if (advance) begin
         if (x == x1_q) begin
            x <= x0_q;
            y <= y + YW'(1);
         end else begin
            x <= x + XW'(1);
         end
      end
   end

   assign last = (x == x1_q) && (y == y1_q);

endmodule

// File: rtl/lt24_window_blitter.sv
// Fills one rectangular LT24 window per command from a solid colour or an
// image ROM, driving the display pixel handshake and the ROM address.
module lt24_window_blitter
   import lt24_window_blitter_pkg::*;
#(
   parameter int WIDTH       = LCD_WIDTH,
   parameter int HEIGHT      = LCD_HEIGHT,
   parameter int ROM_AW      = 17,
   parameter int ROM_LATENCY = 1
) (
   input  logic              clock,
   input  logic              n_reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [7:0]        cmd_x0,
   input  logic [7:0]        cmd_x1,
   input  logic [8:0]        cmd_y0,
   input  logic [8:0]        cmd_y1,
   input  logic              cmd_src,
   input  logic [15:0]       cmd_colour,
   input  logic [ROM_AW-1:0] cmd_rom_base,
   input  logic              abort,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_q,
   output logic [7:0]        xAddr,
   output logic [8:0]        yAddr,
   output logic [15:0]       pixelData,
   output logic              pixelWrite,
   input  logic              pixelReady,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [7:0] X_MAX     = 8'(WIDTH - 1);
   localparam logic [8:0] Y_MAX     = 9'(HEIGHT - 1);
   localparam logic [1:0] WAIT_LAST = 2'(ROM_LATENCY - 1);

   blit_state_t state;
   blit_state_t state_next;

   logic       src_q;
   logic       degen_q;
   logic [1:0] wait_cnt;
   logic       wait_last;
   logic       win_last;
   logic       degen_cmd;
   logic       accept;
   logic       advance;
   logic [7:0] x0_c;
   logic [7:0] x1_c;
   logic [8:0] y0_c;
   logic [8:0] y1_c;

   // Off-panel coordinates are pinned to the last column/row before use.
   assign x0_c = (cmd_x0 > X_MAX) ? X_MAX : cmd_x0;
   assign x1_c = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
   assign y0_c = (cmd_y0 > Y_MAX) ? Y_MAX : cmd_y0;
   assign y1_c = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;

   assign degen_cmd = (x1_c < x0_c) || (y1_c < y0_c);
   assign accept    = (state == ST_IDLE) && cmd_valid;
   assign wait_last = (state == ST_WAIT) && (wait_cnt == WAIT_LAST);
   assign advance   = (state == ST_WRITE) && pixelReady && !win_last && !abort;

   lt24_window_counter #(.XW(8), .YW(9)) u_counter (
      .clock   (clock),
      .n_reset (n_reset),
      .load    (accept),
      .advance (advance),
      .load_x0 (x0_c),
      .load_x1 (x1_c),
      .load_y0 (y0_c),
      .load_y1 (y1_c),
      .x       (xAddr),
      .y       (yAddr),
      .last    (win_last)
   );

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (cmd_valid) state_next = degen_cmd ? ST_FINISH : (cmd_src ? ST_FETCH : ST_WRITE);
         ST_FETCH:  state_next = ST_WAIT;
         ST_WAIT:   if (wait_last) state_next = ST_WRITE;
         ST_WRITE:  if (pixelReady) state_next = win_last ? ST_FINISH : (src_q ? ST_FETCH : ST_WRITE);
         ST_FINISH: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
      if (abort && (state != ST_IDLE)) state_next = ST_IDLE;
   end

   always_comb begin
      cmd_ready = (state == ST_IDLE);
      busy      = (state != ST_IDLE);
      done      = (state == ST_FINISH);
      err       = (state == ST_FINISH) && degen_q;
   end

   // Solid fills keep pixelWrite high across handshakes; ROM fills drop it
   // while the next word is fetched.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         src_q      <= 1'b0;
         degen_q    <= 1'b0;
         wait_cnt   <= '0;
         rom_addr   <= '0;
         pixelData  <= '0;
         pixelWrite <= 1'b0;
      end else begin
         if (state == ST_FETCH)     wait_cnt <= '0;
         else if (state == ST_WAIT) wait_cnt <= wait_cnt + 2'(1);

         if (abort && (state != ST_IDLE)) begin
            pixelWrite <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: if (cmd_valid) begin
                  src_q    <= cmd_src;
                  degen_q  <= degen_cmd;
                  rom_addr <= cmd_rom_base;
                  if (!cmd_src && !degen_cmd) begin
                     pixelData  <= cmd_colour;
                     pixelWrite <= 1'b1;
                  end
               end
               ST_WAIT: if (wait_last) begin
                  pixelData  <= rom_q;
                  pixelWrite <= 1'b1;
               end
               ST_WRITE: if (pixelReady) begin
                  if (win_last) begin
                     pixelWrite <= 1'b0;
                  end else if (src_q) begin
                     rom_addr   <= rom_addr + ROM_AW'(1);
                     pixelWrite <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lt24_window_blitter.sv
// Directed bench for lt24_window_blitter: a raster-order pixel model feeds an
// expected-pixel queue that a negedge monitor checks every handshake against.
module tb_lt24_window_blitter;
   import lt24_window_blitter_pkg::*;

   localparam int ROM_AW = 17;

   logic              clock = 1'b0;
   logic              n_reset = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [7:0]        cmd_x0 = '0;
   logic [7:0]        cmd_x1 = '0;
   logic [8:0]        cmd_y0 = '0;
   logic [8:0]        cmd_y1 = '0;
   logic              cmd_src = 1'b0;
   logic [15:0]       cmd_colour = '0;
   logic [ROM_AW-1:0] cmd_rom_base = '0;
   logic              abort = 1'b0;
   logic [ROM_AW-1:0] rom_addr;
   logic [15:0]       rom_q = '0;
   logic [7:0]        xAddr;
   logic [8:0]        yAddr;
   logic [15:0]       pixelData;
   logic              pixelWrite;
   logic              pixelReady = 1'b0;
   logic              busy;
   logic              done;
   logic              err;

   typedef struct packed {
      logic [7:0]  x;
      logic [8:0]  y;
      logic [15:0] d;
   } pix_t;

   pix_t        expq[$];
   pix_t        exp_px;
   pix_t        first_log[16];
   pix_t        last_px;
   int          n_writes = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          checks = 0;
   int          passes = 0;
   int          popped = 0;
   logic        cur_src = 1'b0;
   logic [16:0] cur_base = '0;

   lt24_window_blitter #(
      .WIDTH(240), .HEIGHT(320), .ROM_AW(ROM_AW), .ROM_LATENCY(1)
   ) dut (
      .clock(clock), .n_reset(n_reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
      .cmd_src(cmd_src), .cmd_colour(cmd_colour), .cmd_rom_base(cmd_rom_base),
      .abort(abort), .rom_addr(rom_addr), .rom_q(rom_q),
      .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
      .pixelWrite(pixelWrite), .pixelReady(pixelReady),
      .busy(busy), .done(done), .err(err)
   );

   initial forever #5 clock = ~clock;

   // Synchronous image ROM whose contents equal the low 16 address bits.
   always @(posedge clock) rom_q <= rom_addr[15:0];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
   endtask

   // Expected pixels: every clamped window coordinate in raster order.
   task automatic buildExpected(input int x0, input int x1, input int y0, input int y1,
                                input bit src, input logic [15:0] colour, input int base);
      int cx0, cx1, cy0, cy1, idx;
      pix_t p;
      logic [16:0] a;
      cx0 = (x0 > LCD_WIDTH - 1) ? LCD_WIDTH - 1 : x0;
      cx1 = (x1 > LCD_WIDTH - 1) ? LCD_WIDTH - 1 : x1;
      cy0 = (y0 > LCD_HEIGHT - 1) ? LCD_HEIGHT - 1 : y0;
      cy1 = (y1 > LCD_HEIGHT - 1) ? LCD_HEIGHT - 1 : y1;
      idx = 0;
      for (int yy = cy0; yy <= cy1; yy++) begin
         for (int xx = cx0; xx <= cx1; xx++) begin
            a   = 17'((base + idx) % (1 << 17));
            p.x = 8'(xx);
            p.y = 9'(yy);
            p.d = src ? a[15:0] : colour;
            expq.push_back(p);
            idx++;
         end
      end
   endtask

   task automatic applyStimulus(input int x0, input int x1, input int y0, input int y1,
                                input bit src, input logic [15:0] colour, input int base);
      checkOutput("cmd_ready_idle", cmd_ready, 1);
      cmd_x0       = 8'(x0);
      cmd_x1       = 8'(x1);
      cmd_y0       = 9'(y0);
      cmd_y1       = 9'(y1);
      cmd_src      = src;
      cmd_colour   = colour;
      cmd_rom_base = 17'(base);
      cmd_valid    = 1'b1;
      buildExpected(x0, x1, y0, y1, src, colour, base);
      cur_src  = src;
      cur_base = 17'(base);
      popped   = 0;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic runToDone(input int period, input int budget);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < budget) begin
         pixelReady = ((n % period) == period - 1);
         @(negedge clock);
         if (done) seen = 1'b1;
         @(posedge clock); #1;
         n++;
      end
      pixelReady = 1'b0;
      checkOutput("done_within_budget", 64'(seen), 1);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_err"}, err, 0);
      checkOutput({tag, "_pixelWrite"}, pixelWrite, 0);
      checkOutput({tag, "_pixelData"}, pixelData, 0);
      checkOutput({tag, "_xAddr"}, xAddr, 0);
      checkOutput({tag, "_yAddr"}, yAddr, 0);
      checkOutput({tag, "_rom_addr"}, rom_addr, 0);
   endtask

   // Handshake monitor: each accepted pixel must be the next model pixel.
   always @(negedge clock) begin
      if (n_reset) begin
         if (pixelWrite && pixelReady) begin
            checkOutput("write_expected", 64'(expq.size() > 0), 1);
            if (expq.size() > 0) begin
               exp_px = expq.pop_front();
               checkOutput("px_x", xAddr, exp_px.x);
               checkOutput("px_y", yAddr, exp_px.y);
               checkOutput("px_data", pixelData, exp_px.d);
            end
            if (n_writes < 16) first_log[n_writes] = {xAddr, yAddr, pixelData};
            last_px = {xAddr, yAddr, pixelData};
            n_writes++;
            popped++;
         end
         if (done) done_cnt++;
         if (err) begin
            err_cnt++;
            checkOutput("err_with_done", done, 1);
         end
         if (!cur_src && busy && !done && expq.size() > 0)
            checkOutput("pw_held", pixelWrite, 1);
         if (cur_src && busy && !done && !pixelWrite && expq.size() > 0)
            checkOutput("rom_addr_hold", rom_addr, cur_base + 17'(popped));
      end
   end

   initial begin
      int d0, w0, e0;
      repeat (3) @(posedge clock);
      #1;
      checkResetValues("reset");
      n_reset = 1'b1;
      @(posedge clock); #1;

      // Solid 2x2 window with pixelReady every third cycle.
      d0 = done_cnt; w0 = n_writes;
      applyStimulus(10, 11, 20, 21, 0, 16'hF920, 0);
      runToDone(3, 100);
      checkOutput("t1_writes", n_writes - w0, 4);
      checkOutput("t1_done", done_cnt - d0, 1);
      checkOutput("t1_px0", first_log[0], {8'd10, 9'd20, 16'hF920});
      checkOutput("t1_px2", first_log[2], {8'd10, 9'd21, 16'hF920});
      checkOutput("t1_px3", first_log[3], {8'd11, 9'd21, 16'hF920});

      // ROM window 3x2 from base 100.
      d0 = done_cnt; w0 = n_writes;
      applyStimulus(24, 26, 143, 144, 1, 16'h0000, 100);
      runToDone(1, 100);
      checkOutput("t2_writes", n_writes - w0, 6);
      checkOutput("t2_done", done_cnt - d0, 1);
      checkOutput("t2_px0", first_log[4], {8'd24, 9'd143, 16'd100});
      checkOutput("t2_px3", first_log[7], {8'd24, 9'd144, 16'd103});
      checkOutput("t2_px5", first_log[9], {8'd26, 9'd144, 16'd105});

      // Degenerate window: err and done together, no pixels.
      e0 = err_cnt; w0 = n_writes;
      applyStimulus(50, 40, 0, 0, 0, RGB_BLUE, 0);
      @(negedge clock);
      checkOutput("t3_done", done, 1);
      checkOutput("t3_err", err, 1);
      checkOutput("t3_pw", pixelWrite, 0);
      @(posedge clock); #1;
      @(negedge clock);
      checkOutput("t3_ready", cmd_ready, 1);
      checkOutput("t3_done_once", done, 0);
      checkOutput("t3_err_count", err_cnt - e0, 1);
      checkOutput("t3_no_writes", n_writes - w0, 0);
      @(posedge clock); #1;

      // Out-of-range corners clamp to a full-screen fill.
      d0 = done_cnt; w0 = n_writes;
      applyStimulus(0, 255, 0, 400, 0, RGB_GREEN, 0);
      runToDone(1, 80000);
      checkOutput("t4_writes", n_writes - w0, 76800);
      checkOutput("t4_done", done_cnt - d0, 1);
      checkOutput("t4_last", last_px, {8'd239, 9'd319, 16'h07E0});

      // Abort together with the third handshake of a 4x1 fill.
      d0 = done_cnt; w0 = n_writes;
      applyStimulus(60, 63, 5, 5, 0, RGB_RED, 0);
      pixelReady = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      abort = 1'b1;
      @(negedge clock);
      checkOutput("t5_px3_x", xAddr, 62);
      @(posedge clock); #1;
      abort = 1'b0;
      pixelReady = 1'b0;
      checkOutput("t5_remaining", expq.size(), 1);
      expq.delete();
      checkOutput("t5_busy", busy, 0);
      checkOutput("t5_pw", pixelWrite, 0);
      checkOutput("t5_no_done", done_cnt - d0, 0);
      checkOutput("t5_writes", n_writes - w0, 3);
      applyStimulus(5, 5, 6, 6, 0, RGB_BLUE, 0);
      runToDone(1, 20);
      checkOutput("t5_new_done", done_cnt - d0, 1);
      checkOutput("t5_new_px", last_px, {8'd5, 9'd6, 16'h001F});

      // Reset pulled during WAIT of a ROM command.
      d0 = done_cnt;
      applyStimulus(0, 1, 0, 0, 1, 16'h0000, 7);
      @(posedge clock); #1;
      #1 n_reset = 1'b0;
      #1;
      checkResetValues("midreset");
      expq.delete();
      checkOutput("t6_no_done", done_cnt - d0, 0);
      @(posedge clock); #1;
      n_reset = 1'b1;
      @(posedge clock); #1;
      applyStimulus(5, 5, 6, 6, 0, RGB_YELLOW, 0);
      runToDone(1, 20);
      checkOutput("t6_done", done_cnt - d0, 1);
      checkOutput("t6_px", last_px, {8'd5, 9'd6, 16'hFFE0});

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
